row_mac_engine: RTL and testbench
=================================

# row_mac_engine

Row-level compute responder for the matrix-vector datapath. It starts when the main controller raises `begin_mult` with a row number on `res_add`. It then reads one matrix row and the operand vector from on-chip memory and multiply-accumulates them, writes the signed result into the result store at address `res_add`, and pulses `done_row` so the controller advances to the next row.

## Interface
Parameters:
- DATA_W, 16: signed operand and result width.
- ROW_LEN, 10: elements per row (columns).
- ROWS, 10: valid row count; legal `res_add` is 0..ROWS-1.
- ACC_W, 2*DATA_W+4: accumulator width.

Ports (one clock, `clk`; reset is asynchronous and active-low, `n_reset`):
- clk  in  1  system clock.
- n_reset  in  1  async active-low reset.
- begin_mult  in  1  level request from the controller; sampled only in IDLE.
- res_add  in  4  row index; latched when the request is accepted.
- rd_en  out  1  memory read strobe.
- rd_addr_a  out  8  matrix address = row*ROW_LEN + col.
- rd_addr_x  out  4  vector address = col.
- rd_data_a  in  DATA_W  matrix element; valid exactly 1 cycle after rd_en.
- rd_data_x  in  DATA_W  vector element; valid exactly 1 cycle after rd_en.
- wr_en  out  1  result write strobe (1-cycle pulse).
- wr_addr  out  4  latched row index.
- wr_data  out  DATA_W  row result.
- done_row  out  1  1-cycle completion pulse.
- row_err  out  1  1-cycle pulse on an out-of-range row.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, FETCH, DRAIN, WRITE, DONE.
- **IDLE**
  - When `begin_mult`=1 and `res_add`<ROWS: latch the row, clear the accumulator and column counter, then go to FETCH.
  - When `begin_mult`=1 and `res_add`>=ROWS: go to DONE with `row_err` set. No reads and no write occur.
- **FETCH** (ROW_LEN cycles)
  - `rd_en`=1; column counter runs 0..ROW_LEN-1.
  - Each cycle accumulates the product of the data returned for the previous column.
  - Go to DRAIN after column ROW_LEN-1 is issued.
- **DRAIN**: accumulate the final product; `rd_en`=0.
- **WRITE**: `wr_en`=1, `wr_addr`=latched row, `wr_data`=converted accumulator.
- **DONE**: `done_row`=1 (plus `row_err` if flagged); return to IDLE.
- **Arithmetic**
  - Product: DATA_W × DATA_W signed gives 2*DATA_W bits, sign-extended to ACC_W.
  - The accumulator cannot overflow for ROW_LEN ≤ 16.
- **Request level**
  - `begin_mult` stays high across consecutive rows.
  - The engine does not sample it in DONE, so no row repeats.
  - In the next IDLE cycle the engine accepts the controller's new `res_add`.
- **Dropped request**: if `begin_mult` falls mid-row, it is ignored and the row completes.

## Timing
- **Reset values**: all outputs 0 and state IDLE. Reset mid-row aborts the row with no write and no `done_row`.
- **Latency**, with the request accepted at cycle t:
  - reads at t+1..t+ROW_LEN;
  - DRAIN at t+ROW_LEN+1;
  - `wr_en` at t+ROW_LEN+2;
  - `done_row` at t+ROW_LEN+3.
- **Row period**
  - Back-to-back rows (level `begin_mult`): next acceptance at t+ROW_LEN+4, giving a period of ROW_LEN+4 cycles (14 by default).
  - Out-of-range row: `done_row` and `row_err` at t+1.
- **Read-address encoding**
  - `rd_addr_a`/`rd_addr_x` are registered and change only while in FETCH.
  - Outside FETCH they hold 0.
- **Result and read handshake**
  - `wr_data` holds 0 except in WRITE.
  - There is no read back-pressure; memory latency is fixed at 1 cycle.

## Configuration
- **`ROW_MAC_SATURATE_EN` defined**
  - Results above +(2^(DATA_W-1)-1) clamp to that value.
  - Results below -2^(DATA_W-1) clamp to that value.
- **`ROW_MAC_SATURATE_EN` undefined**: `wr_data` = accumulator[DATA_W-1:0] (two's-complement wrap).
- Timing is identical in both builds.

## Structure
- **Package `matrix_pkg`** holds:
  - the state enum typedef for IDLE..DONE;
  - the constants ROWS, ROW_LEN, DATA_W;
  - the saturation limit functions.
- **Sub-module `mac_unit`**
  - Signed multiply-accumulate with synchronous clear and enable.
  - The ACC_W accumulator register lives here.
  - The engine FSM, counters and output conversion stay in `row_mac_engine`.

## Test plan
- **Single row**: row 3, a[3][c]=c+1, x[c]=2 → `wr_addr`=3, `wr_data`=110; `done_row` exactly 13 cycles after acceptance; one `wr_en` pulse.
- **Level request for 10 rows**
  - Stimulus: `begin_mult` held high, `res_add` stepped 0..9 on each `done_row`.
  - Response: exactly 10 writes at addresses 0..9, done pulses 14 cycles apart, no duplicate rows.
- **Negative data**: a=-3, x=7 for all columns → `wr_data`=-210.
- **Overflow**: a=x=16'h7FFF for all columns → 16'h7FFF with the macro defined; accumulator[15:0]=16'h000A without it.
- **Out-of-range row**: `res_add`=12 → no `rd_en`, no `wr_en`; `done_row` and `row_err` both high 1 cycle after acceptance.
- **Reset mid-row**: `n_reset` low at FETCH column 5 → all outputs 0 immediately; no write; the next request computes a clean result.

Source files
------------

// File: rtl/matrix_pkg.sv
// matrix_pkg: shared constants, engine state encoding and saturation limits for row_mac_engine.
package matrix_pkg;
  localparam int DATA_W = 16;
  localparam int ROW_LEN = 10;
  localparam int ROWS = 10;
  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, WRITE, DONE} state_t;
  function automatic longint sat_hi(int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction
  function automatic longint sat_lo(int w);
    return -(longint'(1) <<< (w - 1));
  endfunction
endpackage

// File: rtl/mac_unit.sv
// mac_unit: signed multiply-accumulate with synchronous clear and enable.
module mac_unit #(
  parameter int DATA_W = 16,
  parameter int ACC_W = 2 * DATA_W + 4
)(
  input  logic                     clk,
  input  logic                     n_reset,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] x,
  output logic signed [ACC_W-1:0]  acc
);
  logic signed [2*DATA_W-1:0] p;
  assign p = a * x;
  always_ff @(posedge clk or negedge n_reset)
    if (!n_reset) acc <= '0;
    else acc <= clr ? '0 : en ? acc + {{(ACC_W-2*DATA_W){p[2*DATA_W-1]}}, p} : acc;
endmodule

// File: rtl/row_mac_engine.sv
// row_mac_engine: reads one matrix row plus the vector, MACs them and writes the row result.
// Optional ROW_MAC_SATURATE_EN clamps the result to the DATA_W signed range instead of wrapping.
module row_mac_engine import matrix_pkg::*; #(
  parameter int DATA_W = matrix_pkg::DATA_W,
  parameter int ROW_LEN = matrix_pkg::ROW_LEN,
  parameter int ROWS = matrix_pkg::ROWS,
  parameter int ACC_W = 2 * DATA_W + 4
)(
  input  logic                     clk,
  input  logic                     n_reset,
  input  logic                     begin_mult,
  input  logic [3:0]               res_add,
  output logic                     rd_en,
  output logic [7:0]               rd_addr_a,
  output logic [3:0]               rd_addr_x,
  input  logic signed [DATA_W-1:0] rd_data_a,
  input  logic signed [DATA_W-1:0] rd_data_x,
  output logic                     wr_en,
  output logic [3:0]               wr_addr,
  output logic [DATA_W-1:0]        wr_data,
  output logic                     done_row,
  output logic                     row_err,
  output logic                     busy
);
  localparam logic [3:0] ROW_LAST = 4'(ROWS - 1);
  localparam logic [3:0] COL_LAST = 4'(ROW_LEN - 1);
  state_t state;
  logic [3:0] row;
  logic rd_en_d;
  logic accept;
  logic signed [ACC_W-1:0] acc;
  logic [DATA_W-1:0] res;
  assign accept = state == IDLE && begin_mult && res_add <= ROW_LAST;
  assign busy = state != IDLE;
  // read data lands one cycle after its strobe, so the MAC enable trails rd_en
  mac_unit #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac (
    .clk(clk), .n_reset(n_reset), .clr(accept), .en(rd_en_d),
    .a(rd_data_a), .x(rd_data_x), .acc(acc)
  );
`ifdef ROW_MAC_SATURATE_EN
  localparam logic signed [ACC_W-1:0] HI = ACC_W'(sat_hi(DATA_W));
  localparam logic signed [ACC_W-1:0] LO = ACC_W'(sat_lo(DATA_W));
  assign res = acc > HI ? HI[DATA_W-1:0] : acc < LO ? LO[DATA_W-1:0] : acc[DATA_W-1:0];
`else
  logic unused_acc_hi;
  assign unused_acc_hi = ^acc[ACC_W-1:DATA_W];
  assign res = acc[DATA_W-1:0];
`endif
  assign wr_data = wr_en ? res : '0;
  always_ff @(posedge clk or negedge n_reset)
    if (!n_reset) begin
      state <= IDLE;
      row <= '0;
      rd_en <= 1'b0;
      rd_en_d <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_x <= '0;
      wr_en <= 1'b0;
      wr_addr <= '0;
      done_row <= 1'b0;
      row_err <= 1'b0;
    end else begin
      rd_en_d <= rd_en;
      case (state)
        IDLE: if (accept) begin
          row <= res_add;
          rd_en <= 1'b1;
          rd_addr_a <= 8'(res_add) * 8'(ROW_LEN);
          rd_addr_x <= '0;
          state <= FETCH;
        end else if (begin_mult) begin
          row_err <= 1'b1;
          done_row <= 1'b1;
          state <= DONE;
        end
        FETCH: if (rd_addr_x == COL_LAST) begin
          rd_en <= 1'b0;
          rd_addr_a <= '0;
          rd_addr_x <= '0;
          state <= DRAIN;
        end else begin
          rd_addr_a <= rd_addr_a + 8'd1;
          rd_addr_x <= rd_addr_x + 4'd1;
        end
        DRAIN: begin
          wr_en <= 1'b1;
          wr_addr <= row;
          state <= WRITE;
        end
        WRITE: begin
          wr_en <= 1'b0;
          wr_addr <= '0;
          done_row <= 1'b1;
          state <= DONE;
        end
        default: begin
          done_row <= 1'b0;
          row_err <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_row_mac_engine.sv
// tb_row_mac_engine: directed rows with a write/done scoreboard checked by an independent monitor.
module tb_row_mac_engine;
  logic clk = 0, n_reset = 0, begin_mult = 0;
  logic [3:0] res_add = 0;
  logic rd_en, wr_en, done_row, row_err, busy;
  logic [7:0] rd_addr_a;
  logic [3:0] rd_addr_x, wr_addr;
  logic signed [15:0] rd_data_a = 0, rd_data_x = 0;
  logic [15:0] wr_data;
  logic signed [15:0] mem_a [0:99];
  logic signed [15:0] mem_x [0:9];
  typedef struct {logic [3:0] addr; logic signed [15:0] data;} wr_t;
  typedef struct {int cyc; logic err;} dn_t;
  wr_t wr_q[$];
  dn_t dn_q[$];
  int cyc = 0, passed = 0, total = 0, rd_cnt = 0, wr_cnt = 0;

  row_mac_engine dut (
    .clk(clk), .n_reset(n_reset), .begin_mult(begin_mult), .res_add(res_add),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_x(rd_addr_x),
    .rd_data_a(rd_data_a), .rd_data_x(rd_data_x),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .done_row(done_row), .row_err(row_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    rd_data_a <= rd_en ? mem_a[rd_addr_a] : 16'sh5A5A;
    rd_data_x <= rd_en ? mem_x[rd_addr_x] : 16'sh5A5A;
  end

  task automatic check(string name, longint got, longint exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  always @(negedge clk) begin : mon
    wr_t w;
    dn_t d;
    if (n_reset) begin
      if (rd_en) rd_cnt++;
      if (wr_en) begin
        wr_cnt++;
        if (wr_q.size() == 0) check("unexpected_write", 1, 0);
        else begin
          w = wr_q.pop_front();
          check("wr_addr", wr_addr, w.addr);
          check("wr_data", $signed(wr_data), w.data);
        end
      end
      if (done_row) begin
        if (dn_q.size() == 0) check("unexpected_done", 1, 0);
        else begin
          d = dn_q.pop_front();
          check("done_cycle", cyc, d.cyc);
          check("row_err", row_err, d.err);
        end
      end
    end
  end

  task automatic wait_done(string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (!done_row && n < 40);
    if (!done_row) check({name, "_timeout"}, 0, 1);
  endtask

  task automatic run_row(logic [3:0] r, longint exp, logic err);
    dn_q.push_back('{cyc + (err ? 1 : 13), err});
    if (!err) wr_q.push_back('{r, 16'(exp)});
    begin_mult = 1;
    res_add = r;
    wait_done("row");
    begin_mult = 0;
    @(negedge clk);
  endtask

  initial begin
    int rd0, wr0, t0, n;
    longint s;
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int rd0, wr0, t0, n;
    longint s;
    for (int i = 0; i < 100; i++) mem_a[i] = 0;
    for (int c = 0; c < 10; c++) begin mem_x[c] = 2; mem_a[30 + c] = 16'(c + 1); end
    repeat (2) @(negedge clk);
    check("rst_rd_en", rd_en, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_done", done_row, 0);
    check("rst_err", row_err, 0);
    check("rst_busy", busy, 0);
    check("rst_outs", {rd_addr_a, rd_addr_x, wr_addr, wr_data}, 0);
    n_reset = 1;
    @(negedge clk);
    rd0 = rd_cnt; wr0 = wr_cnt;
    run_row(3, 110, 0);
    check("single_reads", rd_cnt - rd0, 10);
    check("single_writes", wr_cnt - wr0, 1);
    for (int c = 0; c < 10; c++) begin
      mem_x[c] = 16'(c - 4);
      for (int r = 0; r < 10; r++) mem_a[r * 10 + c] = 16'(r * 3 - c);
    end
    wr0 = wr_cnt;
    t0 = cyc;
    for (int r = 0; r < 10; r++) begin
      s = 0;
      for (int c = 0; c < 10; c++) s += longint'(r * 3 - c) * longint'(c - 4);
      dn_q.push_back('{t0 + 14 * r + 13, 1'b0});
      wr_q.push_back('{4'(r), 16'(s)});
    end
    begin_mult = 1;
    res_add = 0;
    for (int r = 0; r < 10; r++) begin
      wait_done("level");
      if (r < 9) res_add = 4'(r + 1);
    end
    begin_mult = 0;
    @(negedge clk);
    check("level_writes", wr_cnt - wr0, 10);
    for (int c = 0; c < 10; c++) begin mem_a[50 + c] = -3; mem_x[c] = 7; end
    run_row(5, -210, 0);
    for (int c = 0; c < 10; c++) begin mem_a[90 + c] = 16'sh7FFF; mem_x[c] = 16'sh7FFF; end
`ifdef ROW_MAC_SATURATE_EN
    run_row(9, 32767, 0);
`else
    run_row(9, 10, 0);
`endif
    rd0 = rd_cnt; wr0 = wr_cnt;
    run_row(12, 0, 1);
    check("err_no_reads", rd_cnt - rd0, 0);
    check("err_no_writes", wr_cnt - wr0, 0);
    for (int c = 0; c < 10; c++) begin mem_a[20 + c] = 16'(c); mem_x[c] = 16'(c); end
    begin_mult = 1;
    res_add = 2;
    n = 0;
    while (!(rd_en && rd_addr_x == 5) && n < 40) begin @(negedge clk); n++; end
    check("reach_col5", rd_en && rd_addr_x == 5, 1);
    check("midrow_busy", busy, 1);
    begin_mult = 0;
    n_reset = 0;
    #1;
    check("mid_rst_strobes", {rd_en, wr_en, done_row, row_err, busy}, 0);
    check("mid_rst_outs", {rd_addr_a, rd_addr_x, wr_addr, wr_data}, 0);
    wr0 = wr_cnt;
    repeat (2) @(negedge clk);
    n_reset = 1;
    repeat (15) @(negedge clk);
    check("mid_rst_no_write", wr_cnt - wr0, 0);
    run_row(2, 285, 0);
    repeat (3) @(negedge clk);
    check("wr_q_empty", wr_q.size(), 0);
    check("dn_q_empty", dn_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
